// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: op encodings and default data width.
package stack_pkg;

   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_POP  = 2'b01,
      OP_REP2 = 2'b10,
      OP_REP1 = 2'b11
   } op_t;

   localparam int unsigned STACK_WIDTH = 8;

endpackage

// File: rtl/operand_stack.sv
// LIFO operand stack between unified memory and the ALU; one op per op_en pulse,
// top and next-on-stack exposed combinationally as ALU operands.
module operand_stack
   import stack_pkg::*;
#(
   parameter int unsigned WIDTH = STACK_WIDTH,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_en,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             err
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;
   logic             wr_en;
   logic [CW-1:0]    wr_idx;

   assign count = count_q;
   assign err   = err_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // Illegal ops only raise err; count and entries are left untouched.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      count_d = count_q;
      err_d   = err_q;
      if (op_en) begin
         unique case (op_t'(op))
            OP_PUSH: begin
               if (!full) begin
                  wr_en   = 1'b1;
                  wr_idx  = count_q;
                  count_d = count_q + CW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_POP: begin
               if (!empty) count_d = count_q - CW'(1);
               else        err_d   = 1'b1;
            end
            OP_REP2: begin
               if (count_q >= CW'(2)) begin
                  wr_en   = 1'b1;
                  wr_idx  = count_q - CW'(2);
                  count_d = count_q - CW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_REP1: begin
               if (!empty) begin
                  wr_en  = 1'b1;
                  wr_idx = count_q - CW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
            default: err_d = err_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_idx == CW'(i))) mem_q[i] <= data_in;
         end
      end
   end

   // Decoded reads avoid indexing the array with a wider-than-needed pointer.
   always_comb begin
      tos = '0;
      nos = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((count_q >= CW'(1)) && (CW'(i) == count_q - CW'(1))) tos = mem_q[i];
         if ((count_q >= CW'(2)) && (CW'(i) == count_q - CW'(2))) nos = mem_q[i];
      end
   end

endmodule
